// File: rtl/dsp_pkg.sv
// Shared DSP definitions: CORDIC arctangent table builder, vectoring FSM states
// and the uncompensated CORDIC gain constant.
package dsp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } cordic_state_t;

   // K = prod(sqrt(1 + 2^-2i)) in Q16
   localparam int CORDIC_GAIN_Q16 = 107923;

   // atan(2^-i) as a fraction of the full circle, scaled by 2^32
   function automatic logic [31:0] atan_q32(input int i);
      case (i)
         0:  return 32'h2000_0000;
         1:  return 32'h12E4_051E;
         2:  return 32'h09FB_385B;
         3:  return 32'h0511_11D4;
         4:  return 32'h028B_0D43;
         5:  return 32'h0145_D7E1;
         6:  return 32'h00A2_F61E;
         7:  return 32'h0051_7C55;
         8:  return 32'h0028_BE53;
         9:  return 32'h0014_5F2F;
         10: return 32'h000A_2F98;
         11: return 32'h0005_17CC;
         12: return 32'h0002_8BE6;
         13: return 32'h0001_45F3;
         14: return 32'h0000_A2F9;
         15: return 32'h0000_517C;
         16: return 32'h0000_28BE;
         17: return 32'h0000_145F;
         18: return 32'h0000_0A2F;
         19: return 32'h0000_0517;
         20: return 32'h0000_028B;
         21: return 32'h0000_0145;
         22: return 32'h0000_00A2;
         23: return 32'h0000_0051;
         24: return 32'h0000_0028;
         25: return 32'h0000_0014;
         26: return 32'h0000_000A;
         27: return 32'h0000_0005;
         28: return 32'h0000_0002;
         29: return 32'h0000_0001;
         default: return 32'h0000_0000;
      endcase
   endfunction

   // Entry i = round(atan(2^-i)/(2*pi) * 2^phase_bits), valid for phase_bits 4..31;
   // entries at or beyond iterations are zero.
   function automatic logic [31:0][31:0] atan_table(input int phase_bits, input int iterations);
      logic [31:0][31:0] t;
      logic [32:0]       r;
      t = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < iterations) begin
            r    = {1'b0, atan_q32(i)} + (33'd1 << (31 - phase_bits));
            t[i] = 32'(r >> (32 - phase_bits));
         end
      end
      return t;
   endfunction

endpackage

// File: rtl/mul_acc_phase_detector.sv
// Iterative CORDIC vectoring engine: turns a SIN/COS correlation pair into a
// full-circle phase and a K-scaled magnitude, one micro-rotation per CE cycle.
module mul_acc_phase_detector
   import dsp_pkg::*;
#(
   parameter int MUL_ACC_WIDTH  = 32,
   parameter int PHASE_OUT_BITS = 16,
   parameter int ITERATIONS     = 16
) (
   input  logic                             CLK,
   input  logic                             RESET_N,
   input  logic                             CE,
   input  logic signed [MUL_ACC_WIDTH-1:0]  SIN_ACC_IN,
   input  logic signed [MUL_ACC_WIDTH-1:0]  COS_ACC_IN,
   input  logic                             IN_VALID,
   output logic                             IN_READY,
   output logic        [PHASE_OUT_BITS-1:0] PHASE_OUT,
   output logic        [MUL_ACC_WIDTH:0]    MAGNITUDE_OUT,
   output logic                             OUT_VALID,
   output logic                             OVERRUN
);

   // Two guard bits: one for negating the most-negative input, one for CORDIC gain growth
   localparam int W = MUL_ACC_WIDTH + 2;
   localparam logic [31:0][31:0] ATAN = atan_table(PHASE_OUT_BITS, ITERATIONS);
   localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

   cordic_state_t              state, state_next;
   logic signed [W-1:0]        x, y, x_in, y_in;
   logic [PHASE_OUT_BITS-1:0]  z, atan_i;
   logic [4:0]                 cnt;
   logic                       zero_in;

   function automatic logic [MUL_ACC_WIDTH:0] sat_mag(input logic signed [W-1:0] v);
      if (v[W-1:MUL_ACC_WIDTH+1] != '0) return '1;
      return v[MUL_ACC_WIDTH:0];
   endfunction

   assign x_in = {{2{COS_ACC_IN[MUL_ACC_WIDTH-1]}}, COS_ACC_IN};
   assign y_in = {{2{SIN_ACC_IN[MUL_ACC_WIDTH-1]}}, SIN_ACC_IN};

   always_comb begin
      state_next = state;
      IN_READY   = (state == IDLE);
      atan_i     = ATAN[cnt][PHASE_OUT_BITS-1:0];
      case (state)
         IDLE:    if (IN_VALID) state_next = ITER;
         ITER:    if (cnt == LAST_ITER) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= IDLE;
      else if (CE)  state <= state_next;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         x             <= '0;
         y             <= '0;
         z             <= '0;
         cnt           <= '0;
         zero_in       <= 1'b0;
         PHASE_OUT     <= '0;
         MAGNITUDE_OUT <= '0;
         OUT_VALID     <= 1'b0;
         OVERRUN       <= 1'b0;
      end else if (CE) begin
         OUT_VALID <= (state == DONE);
         OVERRUN   <= IN_VALID & ~IN_READY;
         case (state)
            IDLE: if (IN_VALID) begin
               // Left half-plane: rotate by 180 degrees so the iterations only cover +-90
               if (x_in[W-1]) begin
                  x <= -x_in;
                  y <= -y_in;
                  z <= {1'b1, {(PHASE_OUT_BITS-1){1'b0}}};
               end else begin
                  x <= x_in;
                  y <= y_in;
                  z <= '0;
               end
               cnt     <= '0;
               zero_in <= (x_in == '0) && (y_in == '0);
            end
            ITER: begin
               if (!y[W-1]) begin
                  x <= x + (y >>> cnt);
                  y <= y - (x >>> cnt);
                  z <= z + atan_i;
               end else begin
                  x <= x - (y >>> cnt);
                  y <= y + (x >>> cnt);
                  z <= z - atan_i;
               end
               cnt <= cnt + 5'd1;
            end
            DONE: begin
               PHASE_OUT     <= zero_in ? '0 : z;
               MAGNITUDE_OUT <= sat_mag(x);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_acc_phase_detector.sv
// Self-checking bench for mul_acc_phase_detector against a floating-point
// atan2/hypot reference model.
module tb_mul_acc_phase_detector;

   localparam int  MW = 32;
   localparam int  PB = 16;
   localparam int  IT = 16;
   localparam real PI = 3.14159265358979;

   logic                 CLK = 1'b0;
   logic                 RESET_N = 1'b0;
   logic                 CE = 1'b1;
   logic signed [MW-1:0] SIN_ACC_IN = '0;
   logic signed [MW-1:0] COS_ACC_IN = '0;
   logic                 IN_VALID = 1'b0;
   logic                 IN_READY;
   logic [PB-1:0]        PHASE_OUT;
   logic [MW:0]          MAGNITUDE_OUT;
   logic                 OUT_VALID;
   logic                 OVERRUN;

   int  checks = 0;
   int  errors = 0;
   real k_gain;

   mul_acc_phase_detector #(
      .MUL_ACC_WIDTH(MW), .PHASE_OUT_BITS(PB), .ITERATIONS(IT)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .CE(CE),
      .SIN_ACC_IN(SIN_ACC_IN), .COS_ACC_IN(COS_ACC_IN), .IN_VALID(IN_VALID),
      .IN_READY(IN_READY), .PHASE_OUT(PHASE_OUT), .MAGNITUDE_OUT(MAGNITUDE_OUT),
      .OUT_VALID(OUT_VALID), .OVERRUN(OVERRUN)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic real rabs(input real v);
      return (v < 0.0) ? -v : v;
   endfunction

   function automatic real ref_phase(input longint xv, input longint yv);
      real a;
      a = $atan2(real'(yv), real'(xv)) / (2.0 * PI) * (2.0 ** PB);
      if (a < 0.0) a = a + (2.0 ** PB);
      return a;
   endfunction

   function automatic real phase_dist(input int unsigned got, input real e);
      real d;
      d = real'(got) - e;
      while (d > (2.0 ** (PB - 1))) d = d - (2.0 ** PB);
      while (d < -(2.0 ** (PB - 1))) d = d + (2.0 ** PB);
      return rabs(d);
   endfunction

   function automatic real ref_mag(input longint xv, input longint yv);
      return $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv)) * k_gain;
   endfunction

   // Small vectors lose angular resolution: one LSB of y spans several phase LSBs
   function automatic real phase_tol(input longint xv, input longint yv);
      real m;
      m = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
      if (m < 1.0) return 4.0;
      return 4.0 + 4.0 * (2.0 ** PB) / (2.0 * PI * k_gain * m);
   endfunction

   function automatic real mag_tol(input real e);
      return real'(IT) + 2.0e-6 * e;
   endfunction

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_vector(input longint xv, input longint yv,
                            output int unsigned ph, output longint mg, output int lat);
      COS_ACC_IN = MW'(xv);
      SIN_ACC_IN = MW'(yv);
      IN_VALID   = 1'b1;
      tick();
      IN_VALID = 1'b0;
      lat = 0;
      for (int c = 0; c < 200; c++) begin
         tick();
         lat++;
         if (OUT_VALID) break;
      end
      if (!OUT_VALID) lat = -1;
      ph = PHASE_OUT;
      mg = longint'(MAGNITUDE_OUT);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RESET_N = 1'b0;
      repeat (3) tick();
      checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", IN_READY); end
      checks++; if (PHASE_OUT !== '0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", PHASE_OUT); end
      checks++; if (MAGNITUDE_OUT !== '0) begin errors++; $display("FAIL reset_mag got=%0d exp=0", MAGNITUDE_OUT); end
      checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", OUT_VALID); end
      checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0b exp=0", OVERRUN); end
      @(negedge CLK);
      RESET_N = 1'b1;
      tick();
   endtask

   task automatic test_latency();
      int unsigned ph; longint mg; int lat;
      do_vector(1000, 0, ph, mg, lat);
      checks++; if (lat !== IT + 1) begin errors++; $display("FAIL lat_first got=%0d exp=%0d", lat, IT + 1); end
      checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL ready_with_valid got=%0b exp=1", IN_READY); end
      checks++; if (phase_dist(ph, 0.0) > phase_tol(1000, 0)) begin
         errors++; $display("FAIL phase_cos1000 got=%0d exp=0", ph); end
      checks++; if (rabs(real'(mg) - ref_mag(1000, 0)) > mag_tol(ref_mag(1000, 0))) begin
         errors++; $display("FAIL mag_cos1000 got=%0d exp=%0f", mg, ref_mag(1000, 0)); end
      tick();
      checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL out_valid_width got=%0b exp=0", OUT_VALID); end
   endtask

   task automatic test_axes();
      longint ax[8] = '{0, -1000, 0, 1000, 0, -(64'sd1 <<< 24), 0, 64'sd1 <<< 24};
      longint ay[8] = '{1000, 0, -1000, 1 , 64'sd1 <<< 24, 0, -(64'sd1 <<< 24), 0};
      int unsigned ph; longint mg; int lat; real ep, em;
      ay[3] = 0;
      for (int i = 0; i < 8; i++) begin
         do_vector(ax[i], ay[i], ph, mg, lat);
         ep = ref_phase(ax[i], ay[i]);
         em = ref_mag(ax[i], ay[i]);
         checks++; if (lat !== IT + 1) begin errors++; $display("FAIL axis_lat[%0d] got=%0d exp=%0d", i, lat, IT + 1); end
         checks++; if (phase_dist(ph, ep) > phase_tol(ax[i], ay[i])) begin
            errors++; $display("FAIL axis_phase[%0d] got=%0d exp=%0f", i, ph, ep); end
         checks++; if (rabs(real'(mg) - em) > mag_tol(em)) begin
            errors++; $display("FAIL axis_mag[%0d] got=%0d exp=%0f", i, mg, em); end
      end
   endtask

   task automatic test_extremes();
      int unsigned ph; longint mg; int lat; real em;
      do_vector(-(64'sd1 <<< 31), 0, ph, mg, lat);
      em = ref_mag(-(64'sd1 <<< 31), 0);
      checks++; if (phase_dist(ph, 32768.0) > 4.0) begin
         errors++; $display("FAIL most_neg_phase got=%0d exp=32768", ph); end
      checks++; if (rabs(real'(mg) - em) > mag_tol(em)) begin
         errors++; $display("FAIL most_neg_mag got=%0d exp=%0f", mg, em); end
      do_vector(0, 0, ph, mg, lat);
      checks++; if (ph !== 0) begin errors++; $display("FAIL zero_phase got=%0d exp=0", ph); end
      checks++; if (mg !== 0) begin errors++; $display("FAIL zero_mag got=%0d exp=0", mg); end
      checks++; if (lat !== IT + 1) begin errors++; $display("FAIL zero_lat got=%0d exp=%0d", lat, IT + 1); end
   endtask

   task automatic test_random();
      int unsigned ph; longint mg; int lat; real ep, em;
      longint xv, yv;
      for (int i = 0; i < 40; i++) begin
         xv = longint'($signed($urandom())) >>> $urandom_range(0, 10);
         yv = longint'($signed($urandom())) >>> $urandom_range(0, 10);
         if (rabs(real'(xv)) < 1048576.0 && rabs(real'(yv)) < 1048576.0) xv = xv + 64'sd3000000;
         do_vector(xv, yv, ph, mg, lat);
         ep = ref_phase(xv, yv);
         em = ref_mag(xv, yv);
         checks++; if (lat !== IT + 1) begin errors++; $display("FAIL rand_lat[%0d] got=%0d exp=%0d", i, lat, IT + 1); end
         checks++; if (phase_dist(ph, ep) > phase_tol(xv, yv)) begin
            errors++; $display("FAIL rand_phase[%0d] x=%0d y=%0d got=%0d exp=%0f", i, xv, yv, ph, ep); end
         checks++; if (rabs(real'(mg) - em) > mag_tol(em)) begin
            errors++; $display("FAIL rand_mag[%0d] x=%0d y=%0d got=%0d exp=%0f", i, xv, yv, mg, em); end
      end
   endtask

   task automatic test_back_to_back();
      localparam int P = IT + 2;
      longint vx[3] = '{64'sd5000000, -64'sd7000000, 64'sd123456789};
      longint vy[3] = '{64'sd9000000, 64'sd2500000, -64'sd987654321};
      int ov_cnt = 0;
      int nres = 0;
      int e, j;
      real ep, em;
      COS_ACC_IN = MW'(vx[0]);
      SIN_ACC_IN = MW'(vy[0]);
      IN_VALID   = 1'b1;
      for (int t = 0; t < 3 * P + 6; t++) begin
         tick();
         if (OVERRUN) ov_cnt++;
         if (OUT_VALID) begin
            checks++; if (t !== nres * P + IT + 1) begin
               errors++; $display("FAIL b2b_timing[%0d] got=%0d exp=%0d", nres, t, nres * P + IT + 1); end
            if (nres < 3) begin
               ep = ref_phase(vx[nres], vy[nres]);
               em = ref_mag(vx[nres], vy[nres]);
               checks++; if (phase_dist(PHASE_OUT, ep) > phase_tol(vx[nres], vy[nres])) begin
                  errors++; $display("FAIL b2b_phase[%0d] got=%0d exp=%0f", nres, PHASE_OUT, ep); end
               checks++; if (rabs(real'(MAGNITUDE_OUT) - em) > mag_tol(em)) begin
                  errors++; $display("FAIL b2b_mag[%0d] got=%0d exp=%0f", nres, MAGNITUDE_OUT, em); end
            end
            nres++;
         end
         e = t + 1;
         if (e <= 2 * P) begin
            j = (e + P - 1) / P;
            COS_ACC_IN = MW'(vx[j]);
            SIN_ACC_IN = MW'(vy[j]);
            IN_VALID   = 1'b1;
         end else begin
            IN_VALID = 1'b0;
         end
      end
      checks++; if (nres !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", nres); end
      checks++; if (ov_cnt !== 2 * (IT + 1)) begin
         errors++; $display("FAIL b2b_overrun got=%0d exp=%0d", ov_cnt, 2 * (IT + 1)); end
   endtask

   task automatic test_ce_toggle();
      int lat = -1;
      real ep, em;
      CE = 1'b1;
      COS_ACC_IN = -MW'(32'sd40000000);
      SIN_ACC_IN = MW'(32'sd30000000);
      IN_VALID   = 1'b1;
      tick();
      IN_VALID = 1'b0;
      for (int e = 1; e < 200; e++) begin
         CE = (e % 2 == 0);
         tick();
         if (OUT_VALID) begin lat = e; break; end
      end
      ep = ref_phase(-40000000, 30000000);
      em = ref_mag(-40000000, 30000000);
      checks++; if (lat !== 2 * (IT + 1)) begin errors++; $display("FAIL ce_latency got=%0d exp=%0d", lat, 2 * (IT + 1)); end
      checks++; if (phase_dist(PHASE_OUT, ep) > phase_tol(-40000000, 30000000)) begin
         errors++; $display("FAIL ce_phase got=%0d exp=%0f", PHASE_OUT, ep); end
      checks++; if (rabs(real'(MAGNITUDE_OUT) - em) > mag_tol(em)) begin
         errors++; $display("FAIL ce_mag got=%0d exp=%0f", MAGNITUDE_OUT, em); end
      CE = 1'b0;
      tick();
      checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL ce_hold_valid got=%0b exp=1", OUT_VALID); end
      CE = 1'b1;
      tick();
      checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL ce_clear_valid got=%0b exp=0", OUT_VALID); end
   endtask

   task automatic test_reset_abort();
      int seen = 0;
      int unsigned ph; longint mg; int lat; real ep, em;
      COS_ACC_IN = MW'(32'sd20000000);
      SIN_ACC_IN = MW'(32'sd20000000);
      IN_VALID   = 1'b1;
      tick();
      IN_VALID = 1'b0;
      repeat (5) tick();
      RESET_N = 1'b0;
      #2;
      checks++; if (PHASE_OUT !== '0) begin errors++; $display("FAIL abort_phase got=%0d exp=0", PHASE_OUT); end
      checks++; if (MAGNITUDE_OUT !== '0) begin errors++; $display("FAIL abort_mag got=%0d exp=0", MAGNITUDE_OUT); end
      checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL abort_ready got=%0b exp=1", IN_READY); end
      checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL abort_valid got=%0b exp=0", OUT_VALID); end
      @(negedge CLK);
      RESET_N = 1'b1;
      for (int c = 0; c < IT + 4; c++) begin
         tick();
         if (OUT_VALID) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_valid got=%0d exp=0", seen); end
      do_vector(-3000000, -4000000, ph, mg, lat);
      ep = ref_phase(-3000000, -4000000);
      em = ref_mag(-3000000, -4000000);
      checks++; if (lat !== IT + 1) begin errors++; $display("FAIL abort_next_lat got=%0d exp=%0d", lat, IT + 1); end
      checks++; if (phase_dist(ph, ep) > phase_tol(-3000000, -4000000)) begin
         errors++; $display("FAIL abort_next_phase got=%0d exp=%0f", ph, ep); end
      checks++; if (rabs(real'(mg) - em) > mag_tol(em)) begin
         errors++; $display("FAIL abort_next_mag got=%0d exp=%0f", mg, em); end
   endtask

   initial begin
      k_gain = 1.0;
      for (int i = 0; i < IT; i++) k_gain = k_gain * $sqrt(1.0 + 2.0 ** (-2 * i));
      test_reset();
      test_latency();
      test_axes();
      test_extremes();
      test_random();
      test_back_to_back();
      test_ce_toggle();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_acc_phase_detector.md
# mul_acc_phase_detector

Iterative CORDIC vectoring stage that sits directly downstream of `adc_dac_frontend`. It consumes one `SIN_MUL_ACC`/`COS_MUL_ACC` correlation pair and produces the full-circle phase angle of the received signal relative to the DCO, plus a gain-scaled magnitude. The phase output feeds the phase-increment feedback loop; the magnitude feeds amplitude monitoring.

## Interface
Parameters:
- `MUL_ACC_WIDTH`, 32, width of the signed accumulator inputs
- `PHASE_OUT_BITS`, 16, width of the unsigned full-circle phase output (2^PHASE_OUT_BITS = 360°)
- `ITERATIONS`, 16, number of CORDIC micro-rotations; legal range 4..PHASE_OUT_BITS

Ports:
- `CLK`  in  1  system clock
- `RESET_N`  in  1  asynchronous, active-low reset
- `CE`  in  1  clock enable; all state advances only when `CE`=1
- `SIN_ACC_IN`  in  MUL_ACC_WIDTH  signed, Y component
- `COS_ACC_IN`  in  MUL_ACC_WIDTH  signed, X component
- `IN_VALID`  in  1  input pair valid
- `IN_READY`  out  1  high in IDLE; transfer = `CE & IN_VALID & IN_READY`
- `PHASE_OUT`  out  PHASE_OUT_BITS  atan2(SIN, COS), unsigned, wraps modulo full circle
- `MAGNITUDE_OUT`  out  MUL_ACC_WIDTH+1  unsigned, sqrt(X²+Y²)·K, K≈1.6468 (gain not compensated)
- `OUT_VALID`  out  1  result strobe, one CE cycle
- `OVERRUN`  out  1  one-CE-cycle pulse when `IN_VALID`=1 while not IN_READY (input dropped)

## Operation
- FSM states: IDLE, ITER, DONE.
- IDLE: `IN_READY`=1. On transfer: pre-rotate, load registers, clear iteration counter, go to ITER.
- Pre-rotation on internal width W = MUL_ACC_WIDTH+2 (sign-extended; this absorbs the negation of the most-negative input and the CORDIC gain):
  - If X<0: x=-X, y=-Y, z=2^(PHASE_OUT_BITS-1).
  - Otherwise: x=X, y=Y, z=0.
  - Record `zero_in` = (X==0 && Y==0).
- ITER: iteration i = counter value, 0..ITERATIONS-1, with arithmetic shifts:
  - If y≥0: x+=y>>>i, y-=x>>>i, z+=ATAN[i].
  - Else: x-=y>>>i, y+=x>>>i, z-=ATAN[i].
  - x and y use their pre-update values. z wraps modulo 2^PHASE_OUT_BITS.
  - After iteration ITERATIONS-1, go to DONE.
- DONE:
  - Register `PHASE_OUT` = `zero_in` ? 0 : z.
  - Register `MAGNITUDE_OUT` = x[MUL_ACC_WIDTH:0], saturating to all-ones if x exceeds that range.
  - Assert `OUT_VALID`, go to IDLE.
- `ATAN[i]` = round(atan(2^-i)/(2π)·2^PHASE_OUT_BITS).
- Inputs are not sampled outside a transfer. Dropped inputs are signalled only by `OVERRUN`.

## Timing
- Reset values: state IDLE; `IN_READY`=1; `PHASE_OUT`=0; `MAGNITUDE_OUT`=0; `OUT_VALID`=0; `OVERRUN`=0; internal x/y/z/counter=0.
- Latency: the transfer occurs at CE-edge n. `OUT_VALID`=1 and the outputs update after CE-edge n+ITERATIONS+1.
- `OUT_VALID` is cleared at the next CE edge. It holds while `CE`=0.
- Throughput: one result per ITERATIONS+2 CE cycles. `IN_READY` returns high in the cycle `OUT_VALID` is high, so back-to-back transfers are accepted then.
- `PHASE_OUT`/`MAGNITUDE_OUT` hold their last result until the next DONE.
- `CE`=0 freezes all registers, including the FSM and `OVERRUN`.
- `RESET_N` asserted mid-computation: immediate return to reset values. The in-flight result is discarded and no `OUT_VALID` is generated.
- Boundary inputs:
  - X=most-negative, Y=0 gives phase 2^(PHASE_OUT_BITS-1) with no overflow.
  - X=0, Y<0 gives phase ≈3/4 circle.

## Structure
- Shared package `dsp_pkg` holds:
  - `function automatic` that builds the ATAN constant table for a given PHASE_OUT_BITS/ITERATIONS.
  - The FSM state enum type.
  - The constant CORDIC_GAIN_Q16 = 107923, which benches use for checking.
- No sub-module is needed. Single module with one datapath always_ff and the FSM.

## Test plan
1. COS=1000, SIN=0 → PHASE_OUT=0x0000 ±4, MAGNITUDE_OUT=1647 ±2, OUT_VALID exactly ITERATIONS+1 CE edges after transfer.
2. Axis sweep:
   - SIN=1000, COS=0 → 0x4000 ±4.
   - COS=-1000, SIN=0 → 0x8000 ±4.
   - SIN=-1000, COS=0 → 0xC000 ±4.
   - Magnitude 1647 ±2 in each case.
3. Extremes:
   - COS=-2^31, SIN=0 → 0x8000 ±4, MAGNITUDE saturated or ≈K·2^31 with no sign flip.
   - COS=SIN=0 → PHASE_OUT=0, MAGNITUDE_OUT=0.
4. Handshake: hold IN_VALID high for 3 vectors continuously → one OVERRUN pulse per dropped cycle, results produced every ITERATIONS+2 cycles; toggling CE at 50% doubles latency exactly.
5. Reset abort: assert RESET_N=0 at iteration 5, release → all outputs 0, IN_READY=1, no OUT_VALID; next vector computes correctly.
6. Closed loop: drive inputs from `adc_dac_frontend` with the DCO at the same PHASE_INCREMENT (109377165) → PHASE_OUT stable within ±0x40 over 100 results.
